hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It generates the forwarding selects for the EX-stage operand muxes and the load-use stalls. It drives the flush inputs of the PC select mux (flushpos/flushneg) and the control-bubble mux (ctrlf). It also freezes the pipeline while data memory is busy and keeps saturating stall and flush performance counters.

## Interface
- TIMEOUT, 64: consecutive dmem_busy cycles before mem_timeout is raised (must be ≥2)
- CNTW, 16: width of stall_cnt and flush_cnt

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs2  in  1  ID instruction reads rs2 (R/S/B types)
- ex_rs1, ex_rs2, ex_rd  in  5  register fields of the instruction in EX
- ex_memread, ex_regwrite  in  1  EX control bits
- mem_rd, mem_regwrite  in  5/1  MEM-stage destination and write enable
- wb_rd, wb_regwrite  in  5/1  WB-stage destination and write enable
- ex_branch_valid  in  1  a branch/jump is resolved in EX this cycle
- ex_pred_taken, ex_taken  in  1  predicted direction and actual direction of the EX branch
- dmem_busy  in  1  data memory cannot complete this cycle
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 WB result, 10 MEM result
- pc_stall, ifid_stall  out  1  hold PC and the IF/ID register
- pipe_freeze  out  1  hold every pipeline register
- ifid_flush  out  1  turn IF/ID into a bubble
- ctrlf  out  1  zero the control bits entering ID/EX
- flushpos  out  1  redirect PC to the branch target (taken branch predicted not-taken)
- flushneg  out  1  redirect PC to the branch PC+4 (not-taken branch predicted taken)
- mem_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt  out  CNTW  performance counters

## Operation
- Forwarding is combinational and independent of state.
  - fwd_a = 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a = 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a = 00.
  - fwd_b uses the same rules with ex_rs2. MEM has priority over WB.
- Load-use hazard (lu) = ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || (id_use_rs2 && ex_rd==id_rs2)) && !shadow.
- Mispredict (mp) = ex_branch_valid && (ex_pred_taken != ex_taken).
- Each cycle falls into exactly one class. Priority is FREEZE > MISPRED > LOADUSE > RUN.
  - FREEZE (dmem_busy=1): pipe_freeze=pc_stall=ifid_stall=1. All flush outputs are 0. A pending mp or lu is re-evaluated after the freeze.
  - MISPRED: flushpos=ex_taken, flushneg=!ex_taken, ifid_flush=1, ctrlf=1, no stall. lu is ignored because it comes from the wrong path.
  - LOADUSE: pc_stall=ifid_stall=ctrlf=1. One bubble is inserted.
  - RUN: all control outputs are 0.
- flushpos and flushneg are never both 1.
- State machine (2 bits): RUN, WAIT, SHADOW.
  - RUN→WAIT on dmem_busy. RUN→SHADOW on a MISPRED cycle.
  - SHADOW→RUN on the next non-FREEZE cycle. SHADOW→WAIT on dmem_busy, with the shadow flag kept.
  - WAIT→RUN when dmem_busy=0. Go to SHADOW instead if the shadow flag is set.
- shadow is 1 in SHADOW state, or in WAIT with the shadow flag held. It suppresses lu, because IF/ID holds a flushed bubble with stale rs fields.
- wait_cnt (clog2(TIMEOUT+1) bits):
  - Cleared on every cycle with dmem_busy=0.
  - Incremented on each dmem_busy cycle, saturating.
  - mem_timeout is set when wait_cnt reaches TIMEOUT−1 while dmem_busy=1. It clears only on reset.
- stall_cnt increments on each cycle with pc_stall=1. flush_cnt increments on each MISPRED cycle. Both saturate at all-ones and never wrap.

## Timing
- Forwarding, stall, flush and freeze outputs are combinational from the current inputs and state, with zero-cycle latency.
- Counters and mem_timeout are registered and reflect an event one cycle after it.
- Reset values: state=RUN, shadow flag=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
- While rst_n=0, all control outputs and fwd_a/fwd_b are forced to 0, regardless of inputs.
- Reset during WAIT or SHADOW returns to RUN in the next cycle and drops all pending state.
- A load-use bubble lasts exactly 1 cycle. The next cycle, the load is in MEM and forwarding (10) covers it.
- A MISPRED in cycle T is followed by SHADOW at T+1. lu is suppressed at T+1 only.

## Test plan
- Forwarding: ex_rs1=5, mem_rd=5/mem_regwrite=1, wb_rd=5/wb_regwrite=1 → fwd_a=10. With mem_regwrite=0 → fwd_a=01. With ex_rs1=0 and all writers targeting x0 → fwd_a=00.
- Load-use: ex_memread=1, ex_rd=7, id_rs2=7, id_use_rs2=1 → pc_stall=ifid_stall=ctrlf=1 for one cycle, stall_cnt=1 the next cycle. Same with id_use_rs2=0 → no stall.
- Mispredict: ex_branch_valid=1, pred=0, taken=1 → flushpos=1, ifid_flush=ctrlf=1. Next cycle, a lu-matching ID pattern produces no stall, and flush_cnt=1. pred=1, taken=0 → flushneg=1.
- Freeze priority: dmem_busy=1 with a mispredict in EX for 3 cycles → pipe_freeze=1 and flushpos=0 for 3 cycles. flushpos=1 on the cycle dmem_busy drops. stall_cnt=3.
- Timeout: dmem_busy held high for TIMEOUT cycles → mem_timeout=1 from cycle TIMEOUT and stays 1 after busy drops, until rst_n=0.
- Saturation and reset: with CNTW=4, 20 stall cycles → stall_cnt=15. Assert rst_n=0 mid-WAIT → next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Produces EX operand forwarding selects, load-use stalls, mispredict flushes and
// the data-memory freeze. It also keeps a sticky memory timeout flag and
// saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_memread,
  input  logic            ex_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwrite,
  input  logic            ex_branch_valid,
  input  logic            ex_pred_taken,
  input  logic            ex_taken,
  input  logic            dmem_busy,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            pipe_freeze,
  output logic            ifid_flush,
  output logic            ctrlf,
  output logic            flushpos,
  output logic            flushneg,
  output logic            mem_timeout,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(TIMEOUT);
  localparam logic [WaitW-1:0] WaitTrip = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StWait, StShadow} state_e;

  state_e            state_q, state_d;
  logic              shadow_flag_q, shadow_flag_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]   flush_cnt_q, flush_cnt_d;

  logic shadow, lu, mp;
  logic cls_freeze, cls_mispred, cls_loaduse;

  // EX writes the register file through later stages; only its rd matters here.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return 2'b10;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard detection and cycle classification (FREEZE > MISPRED > LOADUSE > RUN).
  always_comb begin
    // A flushed bubble in IF/ID carries stale rs fields, so lu is masked.
    shadow      = (state_q == StShadow) || ((state_q == StWait) && shadow_flag_q);
    lu          = ex_memread && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2))) && !shadow;
    mp          = ex_branch_valid && (ex_pred_taken != ex_taken);
    cls_freeze  = rst_n && dmem_busy;
    cls_mispred = rst_n && !dmem_busy && mp;
    cls_loaduse = rst_n && !dmem_busy && !mp && lu;
  end

  // Combinational control outputs, all forced low while in reset.
  always_comb begin
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    pipe_freeze = 1'b0;
    ifid_flush  = 1'b0;
    ctrlf       = 1'b0;
    flushpos    = 1'b0;
    flushneg    = 1'b0;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
    end
    if (cls_freeze) begin
      pipe_freeze = 1'b1;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
    end else if (cls_mispred) begin
      flushpos   = ex_taken;
      flushneg   = !ex_taken;
      ifid_flush = 1'b1;
      ctrlf      = 1'b1;
    end else if (cls_loaduse) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      ctrlf      = 1'b1;
    end
  end

  // Next-state for the sequencer, the timeout watchdog and the counters.
  always_comb begin
    state_d       = StRun;
    shadow_flag_d = 1'b0;
    if (dmem_busy) begin
      state_d       = StWait;
      // Entering or staying in WAIT remembers whether a shadow is still owed.
      shadow_flag_d = shadow;
    end else if (mp) begin
      state_d = StShadow;
    end else if ((state_q == StWait) && shadow_flag_q) begin
      state_d = StShadow;
    end

    if (!dmem_busy) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == WaitMax) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    mem_timeout_d = mem_timeout_q || (dmem_busy && (wait_cnt_q >= WaitTrip));

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (cls_mispred && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StRun;
      shadow_flag_q <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_flag_q <= shadow_flag_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle behaviour
// plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNTW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic            id_use_rs2, ex_memread, ex_regwrite, mem_regwrite, wb_regwrite;
  logic            ex_branch_valid, ex_pred_taken, ex_taken, dmem_busy;
  logic [1:0]      fwd_a, fwd_b;
  logic            pc_stall, ifid_stall, pipe_freeze, ifid_flush, ctrlf;
  logic            flushpos, flushneg, mem_timeout;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_valid(ex_branch_valid), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .dmem_busy(dmem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .pipe_freeze(pipe_freeze), .ifid_flush(ifid_flush), .ctrlf(ctrlf),
    .flushpos(flushpos), .flushneg(flushneg), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // exp = {fwd_a, fwd_b, pc_stall, ifid_stall, pipe_freeze, ifid_flush, ctrlf, flushpos, flushneg}
  typedef struct {
    logic [4:0]  id_rs1, id_rs2;
    logic        use2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        memread;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        bv, pt, tk, busy;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] ctl_vec();
    return {fwd_a, fwd_b, pc_stall, ifid_stall, pipe_freeze, ifid_flush, ctrlf,
            flushpos, flushneg};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_regwrite = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    ex_branch_valid = 0; ex_pred_taken = 0; ex_taken = 0; dmem_busy = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs2 = v.use2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_memread = v.memread;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_we; wb_rd = v.wb_rd; wb_regwrite = v.wb_we;
    ex_branch_valid = v.bv; ex_pred_taken = v.pt; ex_taken = v.tk; dmem_busy = v.busy;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Load-use pattern on rs2 (ex_rd=7 loaded, ID reads x7 via rs2).
  task automatic set_lu();
    clear_inputs();
    ex_memread = 1; ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
  endtask

  initial begin
    // id_rs1 id_rs2 use2 ex_rs1 ex_rs2 ex_rd memread mem_rd mem_we wb_rd wb_we bv pt tk busy exp
    vecs.push_back('{0, 0, 0, 5, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 11'b10_00_0000000});
    vecs.push_back('{0, 0, 0, 5, 0, 0, 0, 5, 0, 5, 1, 0, 0, 0, 0, 11'b01_00_0000000});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 11'b00_00_0000000});
    vecs.push_back('{0, 0, 0, 3, 9, 0, 0, 3, 1, 9, 1, 0, 0, 0, 0, 11'b10_01_0000000});
    vecs.push_back('{0, 0, 0, 9, 9, 0, 0, 9, 1, 9, 1, 0, 0, 0, 0, 11'b10_10_0000000});
    vecs.push_back('{1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_1100100});
    vecs.push_back('{1, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_0000000});
    vecs.push_back('{7, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_1100100});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_0000000});
    vecs.push_back('{7, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_0000000});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 11'b00_00_0001110});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 11'b00_00_0001101});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 11'b00_00_0000000});
    vecs.push_back('{1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 1, 0, 11'b00_00_0001110});
    vecs.push_back('{1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 1, 1, 11'b00_00_1110000});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 11'b00_00_0000000});

    clear_inputs();
    rst_n = 1'b0;
    tick();
    // Reset state, with hazard-looking inputs forced off while rst_n is low.
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; dmem_busy = 1;
    ex_branch_valid = 1; ex_taken = 1; #1;
    chk("reset_ctl", 32'(ctl_vec()), 32'd0);
    rst_n = 1'b1;
    clear_inputs(); #1;
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);

    // Table: each vector starts from a fresh RUN state.
    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      apply(vecs[i]); #1;
      chk($sformatf("vec%0d", i), 32'(ctl_vec()), 32'(vecs[i].exp));
    end

    // Load-use bubble lasts one cycle, counted the next cycle.
    do_reset();
    set_lu(); #1;
    chk("lu_stall", 32'({pc_stall, ifid_stall, ctrlf}), 32'b111);
    tick();
    clear_inputs(); mem_rd = 7; mem_regwrite = 1; ex_rs2 = 7; #1;
    chk("lu_after_stall", 32'(pc_stall), 32'd0);
    chk("lu_after_fwd", 32'(fwd_b), 32'b10);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Mispredict: lu suppressed only in the following cycle.
    do_reset();
    ex_branch_valid = 1; ex_pred_taken = 0; ex_taken = 1; #1;
    chk("mp_flushpos", 32'({flushpos, flushneg, ifid_flush, ctrlf}), 32'b1011);
    tick();
    set_lu(); #1;
    chk("mp_shadow_nostall", 32'(pc_stall), 32'd0);
    chk("mp_flush_cnt", 32'(flush_cnt), 32'd1);
    tick(); #1;
    chk("mp_after_shadow_stall", 32'(pc_stall), 32'd1);

    // Freeze dominates a pending mispredict; flush fires when busy drops.
    do_reset();
    ex_branch_valid = 1; ex_pred_taken = 0; ex_taken = 1; dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frz_freeze%0d", i), 32'({pipe_freeze, flushpos}), 32'b10);
      tick();
    end
    dmem_busy = 0; #1;
    chk("frz_release_flush", 32'({pipe_freeze, flushpos, pc_stall}), 32'b010);
    tick();
    set_lu(); #1;
    chk("frz_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("frz_shadow_nostall", 32'(pc_stall), 32'd0);
    chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);

    // Timeout after TIMEOUT busy cycles, sticky until reset.
    do_reset();
    dmem_busy = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      chk($sformatf("to_low%0d", i), 32'(mem_timeout), 32'd0);
      tick();
    end
    chk("to_set", 32'(mem_timeout), 32'd1);
    dmem_busy = 0;
    tick(); tick();
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    // Reset mid-WAIT with a shadow owed: everything drops, lu stalls again.
    ex_branch_valid = 1; ex_pred_taken = 1; ex_taken = 0; #1;
    chk("rw_flushneg", 32'(flushneg), 32'd1);
    tick();
    clear_inputs(); dmem_busy = 1;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("rw_reset_ctl", 32'(ctl_vec()), 32'd0);
    tick();
    rst_n = 1'b1;
    set_lu(); #1;
    chk("rw_timeout_clr", 32'(mem_timeout), 32'd0);
    chk("rw_cnt_clr", 32'({stall_cnt, flush_cnt}), 32'd0);
    chk("rw_run_lu_stall", 32'({pc_stall, pipe_freeze}), 32'b10);

    // Saturation: 20 stall cycles on a 4-bit counter.
    do_reset();
    set_lu();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 20; i++) begin
      clear_inputs(); ex_branch_valid = 1; ex_taken = 1; tick();
    end
    chk("sat_flush_cnt", 32'(flush_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
